// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//
// Dual-issue instruction fetch queue sitting between the instruction TCM read
// port and decode. Up to two {instr, pc} pairs are captured per cycle into a
// circular buffer; the two oldest entries are presented to decode, which
// retires zero, one or two per cycle. A redirect (flush_i) empties the queue.
//
// Ports:
//   clk, rst_n                  core clock, asynchronous active-low reset
//   flush_i                     redirect; empties the queue at the next edge
//   in_valid{0,1}_i             TCM response slot valids (slot 1 alone ignored)
//   in_instr{0,1}_i, in_pc{0,1}_i  TCM response payload
//   in_ready_o                  queue has room for two entries this cycle
//   out_valid{0,1}_o            head / head+1 entry valid
//   out_instr{0,1}_o, out_pc{0,1}_o  head / head+1 payload
//   deq_i                       entries consumed by decode (3 acts as 2)
//   count_o                     current occupancy (0..DEPTH)
// ---------------------------------------------------------------------------
module fetch_queue #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       in_valid0_i,
  input  logic [XLEN-1:0]            in_instr0_i,
  input  logic [XLEN-1:0]            in_pc0_i,
  input  logic                       in_valid1_i,
  input  logic [XLEN-1:0]            in_instr1_i,
  input  logic [XLEN-1:0]            in_pc1_i,
  output logic                       in_ready_o,
  output logic                       out_valid0_o,
  output logic [XLEN-1:0]            out_instr0_o,
  output logic [XLEN-1:0]            out_pc0_o,
  output logic                       out_valid1_o,
  output logic [XLEN-1:0]            out_instr1_o,
  output logic [XLEN-1:0]            out_pc1_o,
  input  logic [1:0]                 deq_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Storage
  logic [XLEN-1:0] instr_mem_q [DEPTH];
  logic [XLEN-1:0] pc_mem_q    [DEPTH];

  // Control state
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  // Derived control
  logic [PTR_W-1:0] wr_ptr_p1;
  logic [PTR_W-1:0] rd_ptr_p1;
  logic             enq_ok;
  logic             we0, we1;
  logic [1:0]       enq_n;
  logic [1:0]       deq_req;
  logic [1:0]       deq_n;

  // Ready depends only on registered occupancy: no pass-through when full.
  assign in_ready_o = (cnt_q <= CNT_W'(DEPTH - 2));

  assign wr_ptr_p1 = wr_ptr_q + PTR_W'(1);
  assign rd_ptr_p1 = rd_ptr_q + PTR_W'(1);

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    enq_ok  = in_ready_o && !flush_i;
    we0     = 1'b0;
    we1     = 1'b0;
    enq_n   = 2'd0;
    deq_req = deq_i;
    deq_n   = 2'd0;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;

    // Slot 1 only counts when slot 0 is also valid (cross-line fetch drops 1).
    if (enq_ok && in_valid0_i) begin
      we0   = 1'b1;
      we1   = in_valid1_i;
      enq_n = in_valid1_i ? 2'd2 : 2'd1;
    end

    if (deq_i == 2'd3) deq_req = 2'd2;
    // Clamp over-request to what is actually held.
    if (cnt_q < CNT_W'(deq_req)) deq_n = cnt_q[1:0];
    else                         deq_n = deq_req;

    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PTR_W'(deq_n);
      wr_ptr_d = wr_ptr_q + PTR_W'(enq_n);
      cnt_d    = cnt_q + CNT_W'(enq_n) - CNT_W'(deq_n);
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge value of its inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: the storage array has no reset; validity is tracked by cnt_q alone,
  // so clearing the data would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (we0) begin
      instr_mem_q[wr_ptr_q] <= in_instr0_i;
      pc_mem_q[wr_ptr_q]    <= in_pc0_i;
    end
    if (we1) begin
      instr_mem_q[wr_ptr_p1] <= in_instr1_i;
      pc_mem_q[wr_ptr_p1]    <= in_pc1_i;
    end
  end

  // Outputs: head and head+1, wrapping modulo DEPTH.
  assign out_valid0_o = (cnt_q >= CNT_W'(1));
  assign out_valid1_o = (cnt_q >= CNT_W'(2));
  assign out_instr0_o = instr_mem_q[rd_ptr_q];
  assign out_pc0_o    = pc_mem_q[rd_ptr_q];
  assign out_instr1_o = instr_mem_q[rd_ptr_p1];
  assign out_pc1_o    = pc_mem_q[rd_ptr_p1];
  assign count_o      = cnt_q;

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
//
// Directed bench for fetch_queue (DEPTH=8, XLEN=32). Inputs are driven 1ns
// after the rising edge and outputs are observed at that same point, so all
// state-derived outputs are stable when compared.
// ---------------------------------------------------------------------------
module tb_fetch_queue;

  localparam int DEPTH = 8;
  localparam int XLEN  = 32;

  logic            clk;
  logic            rst_n;
  logic            flush_i;
  logic            in_valid0_i, in_valid1_i;
  logic [XLEN-1:0] in_instr0_i, in_instr1_i, in_pc0_i, in_pc1_i;
  logic            in_ready_o;
  logic            out_valid0_o, out_valid1_o;
  logic [XLEN-1:0] out_instr0_o, out_instr1_o, out_pc0_o, out_pc1_o;
  logic [1:0]      deq_i;
  logic [3:0]      count_o;

  int n_cmp = 0;
  int n_err = 0;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .in_valid0_i  (in_valid0_i),
    .in_instr0_i  (in_instr0_i),
    .in_pc0_i     (in_pc0_i),
    .in_valid1_i  (in_valid1_i),
    .in_instr1_i  (in_instr1_i),
    .in_pc1_i     (in_pc1_i),
    .in_ready_o   (in_ready_o),
    .out_valid0_o (out_valid0_o),
    .out_instr0_o (out_instr0_o),
    .out_pc0_o    (out_pc0_o),
    .out_valid1_o (out_valid1_o),
    .out_instr1_o (out_instr1_o),
    .out_pc1_o    (out_pc1_o),
    .deq_i        (deq_i),
    .count_o      (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus helpers (no checking inside).
  task automatic idle();
    flush_i     = 1'b0;
    in_valid0_i = 1'b0;
    in_valid1_i = 1'b0;
    in_instr0_i = '0;
    in_instr1_i = '0;
    in_pc0_i    = '0;
    in_pc1_i    = '0;
    deq_i       = 2'd0;
  endtask

  // Drive one cycle of inputs (instr = ~pc), advance past the edge, go idle.
  task automatic step(input logic v0, input logic [31:0] pc0,
                      input logic v1, input logic [31:0] pc1,
                      input logic [1:0] deq, input logic flush);
    in_valid0_i = v0;
    in_pc0_i    = pc0;
    in_instr0_i = ~pc0;
    in_valid1_i = v1;
    in_pc1_i    = pc1;
    in_instr1_i = ~pc1;
    deq_i       = deq;
    flush_i     = flush;
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic test_reset();
    n_cmp++;
    if (count_o !== 4'd0) begin
      n_err++; $display("FAIL reset_count: got %0d expected 0", count_o);
    end
    n_cmp++;
    if ({out_valid0_o, out_valid1_o} !== 2'b00) begin
      n_err++; $display("FAIL reset_valid: got %b expected 00", {out_valid0_o, out_valid1_o});
    end
    n_cmp++;
    if (in_ready_o !== 1'b1) begin
      n_err++; $display("FAIL reset_ready: got %b expected 1", in_ready_o);
    end
  endtask

  task automatic test_dual_enqueue();
    in_valid0_i = 1'b1; in_pc0_i = 32'h100; in_instr0_i = 32'hAAAA0001;
    in_valid1_i = 1'b1; in_pc1_i = 32'h104; in_instr1_i = 32'hAAAA0002;
    @(posedge clk); #1; idle();
    n_cmp++;
    if (count_o !== 4'd2) begin
      n_err++; $display("FAIL dual_count: got %0d expected 2", count_o);
    end
    n_cmp++;
    if ({out_valid0_o, out_valid1_o} !== 2'b11) begin
      n_err++; $display("FAIL dual_valid: got %b expected 11", {out_valid0_o, out_valid1_o});
    end
    n_cmp++;
    if ({out_pc0_o, out_instr0_o} !== {32'h100, 32'hAAAA0001}) begin
      n_err++; $display("FAIL dual_head: got %h/%h expected 100/aaaa0001", out_pc0_o, out_instr0_o);
    end
    n_cmp++;
    if ({out_pc1_o, out_instr1_o} !== {32'h104, 32'hAAAA0002}) begin
      n_err++; $display("FAIL dual_next: got %h/%h expected 104/aaaa0002", out_pc1_o, out_instr1_o);
    end
    step(0, 0, 0, 0, 2'd2, 0);
    n_cmp++;
    if (count_o !== 4'd0 || out_valid0_o !== 1'b0) begin
      n_err++; $display("FAIL dual_drain: got count %0d v0 %b expected 0/0", count_o, out_valid0_o);
    end
  endtask

  task automatic test_cross_line();
    step(1, 32'h200, 0, 32'h204, 2'd0, 0);
    n_cmp++;
    if (count_o !== 4'd1 || out_valid1_o !== 1'b0) begin
      n_err++; $display("FAIL cross_single: got count %0d v1 %b expected 1/0", count_o, out_valid1_o);
    end
    n_cmp++;
    if (out_pc0_o !== 32'h200 || out_instr0_o !== ~32'h200) begin
      n_err++; $display("FAIL cross_head: got %h/%h expected 200/%h", out_pc0_o, out_instr0_o, ~32'h200);
    end
    step(0, 32'h300, 1, 32'h304, 2'd0, 0);
    n_cmp++;
    if (count_o !== 4'd1 || out_pc0_o !== 32'h200) begin
      n_err++; $display("FAIL cross_slot1_only: got count %0d pc %h expected 1/200", count_o, out_pc0_o);
    end
    step(0, 0, 0, 0, 2'd1, 0);
    n_cmp++;
    if (count_o !== 4'd0) begin
      n_err++; $display("FAIL cross_drain: got %0d expected 0", count_o);
    end
  endtask

  // Starts at rd=wr=3, so the eight entries occupy 3..7,0..2 (wrap).
  task automatic test_full_wrap();
    for (int i = 0; i < 3; i++)
      step(1, 32'h300 + 8*i, 1, 32'h304 + 8*i, 2'd0, 0);
    n_cmp++;
    if (count_o !== 4'd6 || in_ready_o !== 1'b1) begin
      n_err++; $display("FAIL full_six: got count %0d ready %b expected 6/1", count_o, in_ready_o);
    end
    step(1, 32'h318, 1, 32'h31C, 2'd0, 0);
    n_cmp++;
    if (count_o !== 4'd8 || in_ready_o !== 1'b0) begin
      n_err++; $display("FAIL full_eight: got count %0d ready %b expected 8/0", count_o, in_ready_o);
    end
    step(1, 32'hDEAD0, 1, 32'hDEAD4, 2'd0, 0);
    n_cmp++;
    if (count_o !== 4'd8) begin
      n_err++; $display("FAIL full_drop: got %0d expected 8", count_o);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (out_valid0_o !== 1'b1 || out_pc0_o !== 32'h300 + 4*i || out_instr0_o !== ~(32'h300 + 4*i)) begin
        n_err++;
        $display("FAIL wrap_order[%0d]: got v%b pc %h instr %h expected pc %h", i, out_valid0_o, out_pc0_o, out_instr0_o, 32'h300 + 4*i);
      end
      step(0, 0, 0, 0, 2'd1, 0);
    end
    n_cmp++;
    if (count_o !== 4'd0 || out_valid0_o !== 1'b0) begin
      n_err++; $display("FAIL wrap_empty: got count %0d v0 %b expected 0/0", count_o, out_valid0_o);
    end
  endtask

  task automatic test_concurrent();
    step(1, 32'h400, 1, 32'h404, 2'd0, 0);
    step(1, 32'h408, 0, 32'h0,   2'd0, 0);
    n_cmp++;
    if (count_o !== 4'd3) begin
      n_err++; $display("FAIL conc_setup: got %0d expected 3", count_o);
    end
    step(1, 32'h40C, 1, 32'h410, 2'd1, 0);
    n_cmp++;
    if (count_o !== 4'd4 || out_pc0_o !== 32'h404 || out_pc1_o !== 32'h408) begin
      n_err++; $display("FAIL conc_enq_deq: got count %0d pcs %h/%h expected 4 404/408", count_o, out_pc0_o, out_pc1_o);
    end
    step(0, 0, 0, 0, 2'd3, 0);
    n_cmp++;
    if (count_o !== 4'd2 || out_pc0_o !== 32'h40C) begin
      n_err++; $display("FAIL conc_deq3: got count %0d pc %h expected 2/40c", count_o, out_pc0_o);
    end
    step(0, 0, 0, 0, 2'd1, 0);
    n_cmp++;
    if (count_o !== 4'd1 || out_pc0_o !== 32'h410 || out_valid1_o !== 1'b0) begin
      n_err++; $display("FAIL conc_one: got count %0d pc %h v1 %b expected 1/410/0", count_o, out_pc0_o, out_valid1_o);
    end
    step(0, 0, 0, 0, 2'd2, 0);
    n_cmp++;
    if (count_o !== 4'd0 || out_valid0_o !== 1'b0) begin
      n_err++; $display("FAIL conc_clamp: got count %0d v0 %b expected 0/0", count_o, out_valid0_o);
    end
  endtask

  task automatic test_flush();
    step(1, 32'h500, 1, 32'h504, 2'd0, 0);
    step(1, 32'h508, 1, 32'h50C, 2'd0, 0);
    step(1, 32'h510, 0, 32'h0,   2'd0, 0);
    n_cmp++;
    if (count_o !== 4'd5) begin
      n_err++; $display("FAIL flush_setup: got %0d expected 5", count_o);
    end
    step(1, 32'h514, 1, 32'h518, 2'd2, 1);
    n_cmp++;
    if (count_o !== 4'd0 || out_valid0_o !== 1'b0 || in_ready_o !== 1'b1) begin
      n_err++; $display("FAIL flush_empty: got count %0d v0 %b rdy %b expected 0/0/1", count_o, out_valid0_o, in_ready_o);
    end
    // deq_i on an empty queue must be ignored while the enqueue lands.
    step(1, 32'h600, 1, 32'h604, 2'd2, 0);
    n_cmp++;
    if (count_o !== 4'd2 || out_pc0_o !== 32'h600 || out_pc1_o !== 32'h604 || out_instr0_o !== ~32'h600) begin
      n_err++; $display("FAIL flush_refill: got count %0d pcs %h/%h expected 2 600/604", count_o, out_pc0_o, out_pc1_o);
    end
  endtask

  task automatic test_async_reset();
    step(1, 32'h700, 1, 32'h704, 2'd0, 0);
    step(1, 32'h708, 1, 32'h70C, 2'd0, 0);
    step(1, 32'h710, 0, 32'h0,   2'd0, 0);
    n_cmp++;
    if (count_o !== 4'd7) begin
      n_err++; $display("FAIL areset_setup: got %0d expected 7", count_o);
    end
    step(0, 0, 0, 0, 2'd2, 0);
    n_cmp++;
    if (count_o !== 4'd5 || in_ready_o !== 1'b1) begin
      n_err++; $display("FAIL areset_five: got count %0d rdy %b expected 5/1", count_o, in_ready_o);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (count_o !== 4'd0 || out_valid0_o !== 1'b0 || in_ready_o !== 1'b1) begin
      n_err++; $display("FAIL areset_immediate: got count %0d v0 %b rdy %b expected 0/0/1", count_o, out_valid0_o, in_ready_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (count_o !== 4'd0) begin
      n_err++; $display("FAIL areset_after: got %0d expected 0", count_o);
    end
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_dual_enqueue();
    test_cross_line();
    test_full_wrap();
    test_concurrent();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
